perf_monitor: RTL and testbench

//  Parametrised cycle/retire/event performance monitor for the core testbench top.

---
 rtl/perf_monitor.sv | 86 ++++++++
 tb/tb_perf_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: cycle/retire/event counters with halt/timeout stop, freeze, clear and registered readout.
// Define PERF_DISPLAY_EN to print a summary on stop (and $finish on timeout); default build is synthesizable.
module perf_monitor #(
    parameter int CYCLE_W = 32,
    parameter int INS_W   = 32,
    parameter int N_EVT   = 4,
    parameter int EVT_W   = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               isHalt,
    input  logic               W_v,
    input  logic [N_EVT-1:0]   evt_v,
    input  logic               freeze,
    input  logic               clear,
    input  logic [4:0]         rd_sel,
    output logic [31:0]        rd_data,
    output logic [CYCLE_W-1:0] cycle,
    output logic               done,
    output logic               timed_out
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] STOP = 1'b1;
    localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(TIMEOUT - 1);
    logic [0:0] state;
    logic [INS_W-1:0] instrs;
    logic [EVT_W-1:0] evt [N_EVT];
    logic [31:0] rd_next;
    logic run, hit;
    assign run = state == RUN && !freeze;
    assign hit = run && TIMEOUT != 0 && cycle == LAST;
    assign done = state == STOP;
    always_comb begin
        rd_next = rd_sel == 5'd0 ? 32'(cycle) : rd_sel == 5'd1 ? 32'(instrs) : '0;
        for (int k = 0; k < N_EVT; k++)
            if (rd_sel == 5'(k + 2)) rd_next = 32'(evt[k]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cycle <= '0;
            instrs <= '0;
            timed_out <= 1'b0;
            rd_data <= '0;
            for (int k = 0; k < N_EVT; k++) evt[k] <= '0;
        end else begin
            rd_data <= rd_next;
            if (clear) begin
                state <= RUN;
                cycle <= '0;
                instrs <= '0;
                timed_out <= 1'b0;
                for (int k = 0; k < N_EVT; k++) evt[k] <= '0;
            end else if (state == RUN) begin
                if (run) begin
                    cycle <= cycle + CYCLE_W'(1);
                    if (W_v && !(&instrs)) instrs <= instrs + INS_W'(1);
                    for (int k = 0; k < N_EVT; k++)
                        if (evt_v[k] && !(&evt[k])) evt[k] <= evt[k] + EVT_W'(1);
                end
                if (isHalt || hit) state <= STOP;
                // halt on the timeout edge is reported as a halt
                timed_out <= hit && !isHalt;
            end
        end
    end
`ifdef PERF_DISPLAY_EN
    logic done_d;
    always_ff @(posedge clk or posedge reset)
        if (reset) done_d <= 1'b0;
        else done_d <= done;
    // fires one cycle after the stop edge, when the final counts are visible
    always @(posedge clk) begin
        if (done && !done_d) begin
            $display("@%0d cycles %0d instrs CPI=%f", cycle, instrs,
                     instrs == 0 ? 0.0 : real'(cycle) / real'(instrs));
            for (int k = 0; k < N_EVT; k++) $display("evt[%0d] %0d", k, evt[k]);
            if (timed_out) begin
                $display("#ran for %0d cycles", TIMEOUT);
                $finish;
            end
        end
    end
`endif
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: vector table, corner sequences and randomized run against a behavioural model.
module tb_perf_monitor;
    logic clk = 0, reset = 0, halt = 0, wv = 0, frz = 0, clr = 0;
    logic [3:0] ev = 0;
    logic [4:0] sel = 0;
    logic [31:0] rd_a, cyc_a, rd_b, cyc_b, rd_c;
    logic [3:0] cyc_c;
    logic done_a, to_a, done_b, to_b, done_c, to_c;
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;

    perf_monitor #(.EVT_W(4)) u_a (.clk(clk), .reset(reset), .isHalt(halt), .W_v(wv), .evt_v(ev),
        .freeze(frz), .clear(clr), .rd_sel(sel), .rd_data(rd_a), .cycle(cyc_a), .done(done_a), .timed_out(to_a));
    perf_monitor #(.TIMEOUT(20)) u_b (.clk(clk), .reset(reset), .isHalt(halt), .W_v(wv), .evt_v(ev),
        .freeze(frz), .clear(clr), .rd_sel(sel), .rd_data(rd_b), .cycle(cyc_b), .done(done_b), .timed_out(to_b));
    perf_monitor #(.CYCLE_W(4), .TIMEOUT(0)) u_c (.clk(clk), .reset(reset), .isHalt(halt), .W_v(wv), .evt_v(ev),
        .freeze(frz), .clear(clr), .rd_sel(sel), .rd_data(rd_c), .cycle(cyc_c), .done(done_c), .timed_out(to_c));

    // reference model of u_a: counts as plain integers, stop/timeout as flags
    localparam longint M_TO = 100000;
    longint m_cyc, m_ins;
    int m_evt[4];
    bit m_stop, m_to;
    logic [31:0] m_rd;

    typedef struct {
        logic h, w, f, c;
        logic [3:0] e;
        logic [4:0] s;
        logic [31:0] cyc, rd;
        logic dn;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_zero();
        m_cyc = 0; m_ins = 0; m_stop = 0; m_to = 0; m_rd = 0;
        for (int k = 0; k < 4; k++) m_evt[k] = 0;
    endtask

    task automatic model_step();
        logic [31:0] r;
        bit hit;
        r = sel == 0 ? 32'(m_cyc) : sel == 1 ? 32'(m_ins) : (sel >= 2 && sel < 6) ? 32'(m_evt[sel-2]) : 32'd0;
        if (clr) model_zero();
        else if (!m_stop) begin
            hit = !frz && m_cyc == M_TO - 1;
            if (!frz) begin
                m_cyc++;
                if (wv && m_ins < 64'hFFFF_FFFF) m_ins++;
                for (int k = 0; k < 4; k++) if (ev[k] && m_evt[k] < 15) m_evt[k]++;
            end
            if (halt) m_stop = 1;
            else if (hit) begin m_stop = 1; m_to = 1; end
        end
        m_rd = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rst();
        halt = 0; wv = 0; frz = 0; clr = 0; ev = 0; sel = 0;
        reset = 1;
        #2;
        model_zero();
        reset = 0;
        #1;
    endtask

    initial begin
        tbl[0]  = '{0,1,0,0,4'h0,5'd1,32'd1,32'd0,0};
        tbl[1]  = '{0,1,0,0,4'h0,5'd1,32'd2,32'd1,0};
        tbl[2]  = '{0,1,1,0,4'h0,5'd1,32'd2,32'd2,0};
        tbl[3]  = '{0,1,1,0,4'h0,5'd1,32'd2,32'd2,0};
        tbl[4]  = '{0,1,1,0,4'h0,5'd1,32'd2,32'd2,0};
        tbl[5]  = '{0,1,0,0,4'h0,5'd1,32'd3,32'd2,0};
        tbl[6]  = '{0,1,0,0,4'h0,5'd1,32'd4,32'd3,0};
        tbl[7]  = '{0,1,0,0,4'h0,5'd1,32'd5,32'd4,0};
        tbl[8]  = '{0,1,1,0,4'h0,5'd1,32'd5,32'd5,0};
        tbl[9]  = '{0,1,1,0,4'h0,5'd1,32'd5,32'd5,0};
        tbl[10] = '{0,1,0,0,4'h0,5'd1,32'd6,32'd5,0};
        tbl[11] = '{0,1,0,0,4'h0,5'd1,32'd7,32'd6,0};
        tbl[12] = '{1,1,0,1,4'hF,5'd0,32'd0,32'd7,0};
        tbl[13] = '{0,1,0,0,4'h0,5'd1,32'd1,32'd0,0};
        tbl[14] = '{0,0,0,0,4'h0,5'd1,32'd2,32'd1,0};
        tbl[15] = '{1,1,1,0,4'h0,5'd1,32'd2,32'd1,1};
        tbl[16] = '{0,1,0,0,4'h0,5'd1,32'd2,32'd1,1};

        // reset state
        reset = 1;
        #2;
        chk("reset_cycle", cyc_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_rd", rd_a, 0);
        reset = 0;
        #1;
        model_zero();

        // freeze / clear / freeze+halt vectors
        for (int i = 0; i < 17; i++) begin
            halt = tbl[i].h; wv = tbl[i].w; frz = tbl[i].f; clr = tbl[i].c; ev = tbl[i].e; sel = tbl[i].s;
            tick();
            chk($sformatf("vec%0d_cycle", i), cyc_a, tbl[i].cyc);
            chk($sformatf("vec%0d_rd", i), rd_a, tbl[i].rd);
            chk($sformatf("vec%0d_done", i), done_a, tbl[i].dn);
        end

        // async reset mid-run at cycle 57
        rst();
        repeat (57) tick();
        chk("pre_reset_cycle", cyc_a, 57);
        #3 reset = 1;
        #1;
        chk("async_reset_cycle", cyc_a, 0);
        chk("async_reset_done", done_a, 0);
        chk("async_reset_rd", rd_a, 0);
        model_zero();
        reset = 0;

        // halt at cycle 9 with a retire every cycle
        rst();
        wv = 1; sel = 1;
        repeat (9) tick();
        chk("halt_pre_done", done_a, 0);
        halt = 1;
        tick();
        halt = 0;
        chk("halt_done", done_a, 1);
        chk("halt_cycle", cyc_a, 10);
        tick();
        chk("halt_instrs", rd_a, 10);
        chk("halt_hold_cycle", cyc_a, 10);
        chk("halt_timed_out", to_a, 0);

        // timeout at 20 cycles, then halt coinciding with the timeout edge
        rst();
        repeat (19) tick();
        chk("to_pre_done", done_b, 0);
        tick();
        chk("to_cycle", cyc_b, 20);
        chk("to_done", done_b, 1);
        chk("to_flag", to_b, 1);
        repeat (3) tick();
        chk("to_hold_cycle", cyc_b, 20);
        rst();
        repeat (19) tick();
        halt = 1;
        tick();
        halt = 0;
        chk("to_halt_done", done_b, 1);
        chk("to_halt_flag", to_b, 0);
        chk("to_halt_cycle", cyc_b, 20);

        // event saturation and readout
        rst();
        ev = 4'b0010; sel = 3;
        repeat (20) tick();
        chk("evt_sat_rd", rd_a, 15);
        ev = 0; sel = 9;
        tick();
        chk("evt_invalid_rd", rd_a, 0);

        // 4-bit cycle wrap without timeout
        rst();
        repeat (18) tick();
        chk("wrap_cycle", cyc_c, 2);
        chk("wrap_done", done_c, 0);

        // randomized run against the model
        rst();
        for (int i = 0; i < 400; i++) begin
            halt = $urandom_range(0, 39) == 0;
            clr = $urandom_range(0, 29) == 0;
            frz = $urandom_range(0, 3) == 0;
            wv = $urandom_range(0, 1) == 1;
            ev = 4'($urandom);
            sel = 5'($urandom_range(0, 7));
            tick();
            chk("rnd_cycle", cyc_a, m_cyc);
            chk("rnd_done", done_a, m_stop);
            chk("rnd_timed_out", to_a, m_to);
            chk("rnd_rd", rd_a, m_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
